pipe_reg_elastic: RTL

PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

---
 rtl/pipe_reg_elastic.sv | 97 +++++++++
 1 files changed

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: a two-entry skid buffer with a registered
// valid/ready handshake on both sides. No output depends combinationally
// on any input. It also keeps a saturating count of cycles in which
// downstream applied backpressure.
module pipe_reg_elastic #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    // EMPTY: nothing held; BUSY: main holds the head; FULL: main + skid hold two.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // Handshake FSM; out_valid/in_ready are registered alongside the state.
    // NOTE: non-blocking assignments so every register updates from the
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            main_q    <= RST_VAL;
            skid_q    <= RST_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= BUSY;
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state    <= FULL;
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                    end else if (out_fire) begin
                        // main keeps the last delivered value after draining
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state    <= BUSY;
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles with data offered but refused downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush &&
                     stall_cnt != {CNT_WIDTH{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
